gf180mcu_fd_sc_mcu7t5v0__oai211_bist: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv | 151 +++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv
// gf180mcu_fd_sc_mcu7t5v0__oai211_bist
// Exhaustive self-test sequencer for the OAI211 standard cell. It walks the
// 16 input vectors onto A1/A2/B/C, holds each vector for SETTLE cycles,
// samples the cell's ZN on the last hold cycle and counts the samples that
// disagree with ZN = ~((A1|A2)&B&C). The result is reported through
// DONE/PASS/ERRCNT.
// Build option: define GF180MCU_FD_SC_MCU7T5V0_OAI211_BIST_FAILLOG_EN to
// capture the index of the first failing vector on FAIL_VEC. Without the
// macro, FAIL_VEC is tied to 0.
module gf180mcu_fd_sc_mcu7t5v0__oai211_bist #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire        VDD,
    inout  wire        VSS,
    input  logic       START,
    input  logic       ZN,
    output logic       A1,
    output logic       A2,
    output logic       B,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] ERRCNT,
    output logic [3:0] FAIL_VEC
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The last hold-counter value of a vector; ZN is sampled on this cycle.
    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] hold_q, hold_d;
    logic [4:0] errcnt_q, errcnt_d;

    logic       sample;
    logic       zn_exp;
    logic       mismatch;
    logic       start_acc;

    // The supply pins are only feed-throughs for the cell-check structure.
    wire unused_supply;
    assign unused_supply = VDD ^ VSS;

    // A run starts only from IDLE or DONE; START during RUN is ignored.
    assign start_acc = START && (state_q != ST_RUN);
    assign sample    = (state_q == ST_RUN) && (hold_q == HOLD_LAST);
    assign zn_exp    = ~((vec_q[0] | vec_q[1]) & vec_q[2] & vec_q[3]);
    assign mismatch  = sample && (ZN != zn_exp);

    // Next-state logic for the run controller, vector walk and error counter.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        hold_d   = hold_q;
        errcnt_d = errcnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d  = ST_RUN;
                    vec_d    = 4'd0;
                    hold_d   = 4'd0;
                    errcnt_d = 5'd0;
                end
            end
            ST_RUN: begin
                // At most 16 mismatches, so the 5-bit counter never wraps.
                if (mismatch) begin
                    errcnt_d = errcnt_q + 5'd1;
                end
                if (sample) begin
                    hold_d = 4'd0;
                    vec_d  = vec_q + 4'd1;
                    if (vec_q == 4'd15) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run and discards partial results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            vec_q    <= 4'd0;
            hold_q   <= 4'd0;
            errcnt_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            hold_q   <= hold_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign BUSY   = (state_q == ST_RUN);
    assign DONE   = (state_q == ST_DONE);
    assign PASS   = DONE && (errcnt_q == 5'd0);
    assign ERRCNT = errcnt_q;

    // The cell inputs are parked at 0 whenever no run is in progress.
    assign A1 = BUSY & vec_q[0];
    assign A2 = BUSY & vec_q[1];
    assign B  = BUSY & vec_q[2];
    assign C  = BUSY & vec_q[3];

`ifdef GF180MCU_FD_SC_MCU7T5V0_OAI211_BIST_FAILLOG_EN
    logic [3:0] failvec_q, failvec_d;

    // Capture the vector index of the first mismatch in a run. A zero error
    // count at the mismatch identifies it as the first one.
    always_comb begin
        failvec_d = failvec_q;
        if (start_acc) begin
            failvec_d = 4'd0;
        end else if (mismatch && (errcnt_q == 5'd0)) begin
            failvec_d = vec_q;
        end
    end

    // First-failure register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            failvec_q <= 4'd0;
        end else begin
            failvec_q <= failvec_d;
        end
    end

    assign FAIL_VEC = failvec_q;
`else
    wire unused_start_acc;
    assign unused_start_acc = start_acc;
    assign FAIL_VEC = 4'd0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai211_bist.sv
// Testbench for gf180mcu_fd_sc_mcu7t5v0__oai211_bist. Three instances use
// SETTLE = 1, 2 and 3. Each instance's ZN is produced by a 16-entry cell
// response table indexed by the vector it drives. The expected results are
// derived from that table and the OAI211 truth set, where ZN is 0 only for
// v = 13, 14 and 15.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai211_bist;

    localparam logic [15:0] GOOD_RESP = 16'h1FFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [15:0] resp;

    wire         vdd;
    wire         vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    wire [2:0]   a1, a2, b, c, busy, done, pass;
    wire [4:0]   errcnt [3];
    wire [3:0]   failvec [3];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        wire [3:0] vec_w;
        wire       zn_w;
        assign vec_w = {c[k], b[k], a2[k], a1[k]};
        assign zn_w  = resp[vec_w];

        gf180mcu_fd_sc_mcu7t5v0__oai211_bist #(.SETTLE(k + 1)) u_dut (
            .CLK      (clk),
            .RST      (rst),
            .VDD      (vdd),
            .VSS      (vss),
            .START    (start[k]),
            .ZN       (zn_w),
            .A1       (a1[k]),
            .A2       (a2[k]),
            .B        (b[k]),
            .C        (c[k]),
            .BUSY     (busy[k]),
            .DONE     (done[k]),
            .PASS     (pass[k]),
            .ERRCNT   (errcnt[k]),
            .FAIL_VEC (failvec[k])
        );
    end

    function automatic logic [3:0] vec_of(input int k);
        return {c[k], b[k], a2[k], a1[k]};
    endfunction

    // Reference: number of vectors whose response differs from OAI211.
    function automatic int ref_errcnt(input logic [15:0] r);
        int n = 0;
        for (int v = 0; v < 16; v++) begin
            if (r[v] != (v < 13)) n++;
        end
        return n;
    endfunction

    // Reference: index of the first failing vector, or 0 without fail logging.
    function automatic int ref_failvec(input logic [15:0] r);
`ifdef GF180MCU_FD_SC_MCU7T5V0_OAI211_BIST_FAILLOG_EN
        for (int v = 0; v < 16; v++) begin
            if (r[v] != (v < 13)) return v;
        end
`endif
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Run one pulsed-START self-test on instance k against response table r.
    task automatic do_run(input int k, input logic [15:0] r, input string nm);
        int s;
        int exp_err;
        s       = k + 1;
        exp_err = ref_errcnt(r);
        resp    = r;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        check($sformatf("%s_clear_err", nm), errcnt[k], 0);
        check($sformatf("%s_clear_fv", nm), failvec[k], 0);
        for (int n = 0; n < 16 * s; n++) begin
            check($sformatf("%s_run%0d", nm, n),
                  {busy[k], done[k], vec_of(k)}, {1'b1, 1'b0, 4'(n / s)});
            @(negedge clk);
        end
        check($sformatf("%s_done", nm), {busy[k], done[k], vec_of(k)}, 6'b01_0000);
        check($sformatf("%s_errcnt", nm), errcnt[k], exp_err);
        check($sformatf("%s_pass", nm), pass[k], 1'(exp_err == 0));
        check($sformatf("%s_failvec", nm), failvec[k], ref_failvec(r));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 3'b000;
        resp  = GOOD_RESP;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ctl%0d", k),
                  {busy[k], done[k], pass[k], vec_of(k)}, 7'd0);
            check($sformatf("reset_err%0d", k), errcnt[k], 0);
            check($sformatf("reset_fv%0d", k), failvec[k], 0);
        end
        rst = 1'b0;

        do_run(0, GOOD_RESP, "good_s1");
        do_run(0, 16'hFFFF, "stuck1_s1");
        do_run(1, 16'h0000, "stuck0_s2");
        do_run(0, GOOD_RESP ^ 16'h0020, "inv5_s1");

        // START held high through a whole S=3 run, then still high in DONE.
        resp = 16'h0000;
        @(negedge clk);
        start[2] = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 48; n++) begin
            check($sformatf("hold_run%0d", n),
                  {busy[2], done[2], vec_of(2)}, {1'b1, 1'b0, 4'(n / 3)});
            @(negedge clk);
        end
        check("hold_done", {busy[2], done[2]}, 2'b01);
        check("hold_errcnt", errcnt[2], 13);
        @(negedge clk);
        check("hold_restart", {busy[2], done[2], vec_of(2)}, 6'b10_0000);
        check("hold_restart_err", errcnt[2], 0);
        start[2] = 1'b0;

        // Reset in the middle of a run on the S=1 instance.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int n = 0; n < 7; n++) @(negedge clk);
        check("midrun_err_before", errcnt[0], 7);
        check("midrun_busy_before", busy[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_ctl", {busy[0], done[0], pass[0], vec_of(0)}, 7'd0);
        check("midrun_rst_err", errcnt[0], 0);
        check("midrun_rst_busy2", busy[2], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        do_run(0, GOOD_RESP, "after_rst");

        // Randomized cell responses on randomly chosen instances.
        for (int i = 0; i < 8; i++) begin
            int          k;
            logic [15:0] r;
            k = int'($urandom_range(0, 2));
            r = 16'($urandom);
            if (i == 0) r = GOOD_RESP ^ 16'h8421;
            do_run(k, r, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
